window_noise_filter: RTL and testbench

//  Parametrised 3x3 binary noise filter for the camera pipeline, replacing the fixed 12-bit filter.

---
 rtl/window_noise_filter.sv | 116 +++++++++++
 tb/tb_window_noise_filter.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/window_noise_filter.sv
// 3x3 binary noise filter: two line buffers feed a register window whose centre
// is binarised by a runtime-selected rule, with border masking and frame restart.
module window_noise_filter #(
    parameter int DATA_W     = 12,
    parameter int LINE_W     = 640,
    parameter int SUM_THRESH = 8000,
    parameter int CNT_THRESH = 8
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic [DATA_W-1:0] iDATA,
    input  logic              iDVAL,
    input  logic              iSOF,
    input  logic [1:0]        iMODE,
    output logic [DATA_W-1:0] oDATA,
    output logic              oDVAL,
    output logic              oBORDER
);

    localparam int COL_W = (LINE_W > 1) ? $clog2(LINE_W) : 1;
    localparam int SUM_W = DATA_W + 4;
    localparam logic [SUM_W-1:0] SUM_T = SUM_W'(SUM_THRESH);
    localparam logic [3:0]       CNT_T = 4'(CNT_THRESH);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(LINE_W - 1);

    typedef enum logic [1:0] {
        MODE_PASS   = 2'd0,
        MODE_SUM    = 2'd1,
        MODE_COUNT  = 2'd2,
        MODE_BYPASS = 2'd3
    } mode_t;

    logic [DATA_W-1:0] lineBuf0 [LINE_W];
    logic [DATA_W-1:0] lineBuf1 [LINE_W];

    logic [COL_W-1:0]  col, colEff;
    logic [1:0]        row, rowEff;
    logic [DATA_W-1:0] win [3][2];
    logic [DATA_W-1:0] tap [3];
    logic [DATA_W-1:0] centre;
    logic [SUM_W-1:0]  sum;
    logic [3:0]        count;
    logic              winValid;
    logic [DATA_W-1:0] result;

    // The incoming column is used combinationally so the output lands one cycle
    // after acceptance; only the two older window columns are registered.
    always_comb begin
        colEff   = iSOF ? '0 : col;
        rowEff   = iSOF ? '0 : row;
        tap[0]   = lineBuf1[colEff];
        tap[1]   = lineBuf0[colEff];
        tap[2]   = iDATA;
        centre   = win[1][1];
        sum      = '0;
        count    = '0;
        for (int unsigned r = 0; r < 3; r++) begin
            sum   = sum + SUM_W'(win[r][0]) + SUM_W'(win[r][1]) + SUM_W'(tap[r]);
            count = count + {3'b000, |win[r][0]} + {3'b000, |win[r][1]} + {3'b000, |tap[r]};
        end
        winValid = (rowEff == 2'd2) && (colEff >= COL_W'(2));
        result   = '0;
        case (mode_t'(iMODE))
            MODE_PASS:   result = (centre != '0) ? '1 : '0;
            MODE_SUM:    result = (sum > SUM_T) ? '1 : '0;
            MODE_COUNT:  result = (count >= CNT_T) ? '1 : '0;
            MODE_BYPASS: result = centre;
            default:     result = '0;
        endcase
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            col <= '0;
            row <= '0;
            for (int unsigned r = 0; r < 3; r++) begin
                win[r][0] <= '0;
                win[r][1] <= '0;
            end
        end else if (iDVAL) begin
            if (colEff == COL_LAST) begin
                col <= '0;
                row <= (rowEff == 2'd2) ? 2'd2 : rowEff + 2'd1;
            end else begin
                col <= colEff + COL_W'(1);
                row <= rowEff;
            end
            for (int unsigned r = 0; r < 3; r++) begin
                win[r][0] <= win[r][1];
                win[r][1] <= tap[r];
            end
        end
    end

    // Line buffers are deliberately unreset; row masking hides stale contents.
    always_ff @(posedge iCLK) begin
        if (iDVAL) begin
            lineBuf0[colEff] <= iDATA;
            lineBuf1[colEff] <= lineBuf0[colEff];
        end
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            oDATA   <= '0;
            oDVAL   <= 1'b0;
            oBORDER <= 1'b0;
        end else begin
            oDVAL   <= iDVAL;
            oBORDER <= iDVAL && !winValid;
            if (iDVAL)
                oDATA <= winValid ? result : '0;
        end
    end

endmodule

// File: tb/tb_window_noise_filter.sv
// Directed bench for window_noise_filter with LINE_W=8; expected values are
// derived by hand from the window/border rules.
module tb_window_noise_filter;

    localparam int DW = 12;
    localparam int LW = 8;

    logic          iCLK = 1'b0;
    logic          iRST;
    logic [DW-1:0] iDATA;
    logic          iDVAL;
    logic          iSOF;
    logic [1:0]    iMODE;
    logic [DW-1:0] oDATA;
    logic          oDVAL;
    logic          oBORDER;

    int checks = 0;
    int errors = 0;

    window_noise_filter #(
        .DATA_W    (DW),
        .LINE_W    (LW),
        .SUM_THRESH(8000),
        .CNT_THRESH(8)
    ) dut (
        .iCLK   (iCLK),
        .iRST   (iRST),
        .iDATA  (iDATA),
        .iDVAL  (iDVAL),
        .iSOF   (iSOF),
        .iMODE  (iMODE),
        .oDATA  (oDATA),
        .oDVAL  (oDVAL),
        .oBORDER(oBORDER)
    );

    always #5 iCLK = ~iCLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one pixel, check the registered output, then idle for gap cycles.
    task automatic pix(input logic [DW-1:0] d, input bit sof, input logic [1:0] m,
                       input logic [DW-1:0] ed, input bit eb, input int gap, input string tag);
        @(negedge iCLK);
        iDATA = d; iDVAL = 1'b1; iSOF = sof; iMODE = m;
        @(posedge iCLK);
        #1;
        iDVAL = 1'b0; iSOF = 1'b0;
        chk({tag, ".dval"}, 32'(oDVAL), 32'd1);
        chk({tag, ".data"}, 32'(oDATA), 32'(ed));
        chk({tag, ".border"}, 32'(oBORDER), 32'(eb));
        repeat (gap) begin
            @(posedge iCLK);
            #1;
            chk({tag, ".gapdval"}, 32'(oDVAL), 32'd0);
            chk({tag, ".gaphold"}, 32'(oDATA), 32'(ed));
        end
    endtask

    // Uniform frame starting with SOF; validVal is expected wherever the window is valid.
    task automatic frame(input logic [DW-1:0] d, input logic [1:0] m, input int rows,
                         input logic [DW-1:0] validVal, input int gap, input string tag);
        for (int r = 0; r < rows; r++)
            for (int c = 0; c < LW; c++) begin
                bit v;
                v = (r >= 2) && (c >= 2);
                pix(d, (r == 0) && (c == 0), m, v ? validVal : '0, !v, gap,
                    $sformatf("%s(%0d,%0d)", tag, c, r));
            end
    endtask

    initial begin
        iRST = 1'b0; iDATA = '0; iDVAL = 1'b0; iSOF = 1'b0; iMODE = 2'd0;
        #12;
        chk("rst.data", 32'(oDATA), 32'd0);
        chk("rst.dval", 32'(oDVAL), 32'd0);
        chk("rst.border", 32'(oBORDER), 32'd0);
        @(negedge iCLK);
        iRST = 1'b1;

        // Full-scale frame in SUM mode, back-to-back and with 3-cycle gaps
        frame(12'hFFF, 2'd1, 4, 12'hFFF, 0, "sum");
        frame(12'hFFF, 2'd1, 4, 12'hFFF, 3, "gap");

        // Small uniform value: sum 2619 fails SUM, count 9 passes COUNT
        frame(12'h123, 2'd1, 3, 12'h000, 0, "sumlow");
        frame(12'h123, 2'd2, 3, 12'hFFF, 0, "cnt9");

        // Single-pixel spot at (4,2): COUNT rejects it, PASS marks only centre (4,2)
        for (int pass = 0; pass < 2; pass++)
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < LW; c++) begin
                    bit v;
                    logic [DW-1:0] e;
                    v = (r >= 2) && (c >= 2);
                    e = (pass == 1 && r == 3 && c == 5) ? 12'hFFF : 12'h000;
                    pix((r == 2 && c == 4) ? 12'h001 : 12'h000, (r == 0) && (c == 0),
                        (pass == 0) ? 2'd2 : 2'd0, v ? e : 12'h000, !v, 0,
                        $sformatf("%s(%0d,%0d)", (pass == 0) ? "spotcnt" : "spotpass", c, r));
                end

        // Mode switch SUM->BYPASS between two adjacent valid pixels
        frame(12'h123, 2'd1, 2, 12'h000, 0, "msw");
        pix(12'h123, 1'b0, 2'd1, 12'h000, 1'b1, 0, "msw.c0");
        pix(12'h123, 1'b0, 2'd1, 12'h000, 1'b1, 0, "msw.c1");
        pix(12'h123, 1'b0, 2'd1, 12'h000, 1'b0, 0, "msw.sum");
        pix(12'h123, 1'b0, 2'd3, 12'h123, 1'b0, 0, "msw.bypass");

        // Mid-line SOF at (5,3) restarts counters; next two rows fully masked
        frame(12'hFFF, 2'd1, 3, 12'hFFF, 0, "sof");
        for (int c = 0; c < 5; c++)
            pix(12'hFFF, 1'b0, 2'd1, (c >= 2) ? 12'hFFF : 12'h000, c < 2, 0,
                $sformatf("sof.r3c%0d", c));
        pix(12'hFFF, 1'b1, 2'd1, 12'h000, 1'b1, 0, "sof.mid");
        for (int i = 1; i < 2 * LW; i++)
            pix(12'hFFF, 1'b0, 2'd1, 12'h000, 1'b1, 0, $sformatf("sof.mask%0d", i));
        for (int c = 0; c < 4; c++)
            pix(12'hFFF, 1'b0, 2'd1, (c >= 2) ? 12'hFFF : 12'h000, c < 2, 0,
                $sformatf("sof.row2c%0d", c));

        // Asynchronous reset while outputs are live, then counters restart without SOF
        #1;
        iRST = 1'b0;
        #1;
        chk("arst.data", 32'(oDATA), 32'd0);
        chk("arst.dval", 32'(oDVAL), 32'd0);
        chk("arst.border", 32'(oBORDER), 32'd0);
        @(negedge iCLK);
        iRST = 1'b1;
        for (int i = 0; i < 2 * LW; i++)
            pix(12'hFFF, 1'b0, 2'd1, 12'h000, 1'b1, 0, $sformatf("arst.mask%0d", i));
        for (int c = 0; c < 4; c++)
            pix(12'hFFF, 1'b0, 2'd1, (c >= 2) ? 12'hFFF : 12'h000, c < 2, 0,
                $sformatf("arst.row2c%0d", c));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
